vga_rx_decoder: RTL and testbench



---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_sync_edge.sv | 32 +++
 rtl/vga_rx_decoder.sv | 197 +++++++++++++++++++
 tb/tb_vga_rx_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : shared 800x600 VGA timing constants, decoder state and coordinates
// Revision: 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int VGA_RES_H  = 800;
  localparam int VGA_RES_V  = 600;
  localparam int VGA_BLK_HF = 40;
  localparam int VGA_BLK_HT = 128;
  localparam int VGA_BLK_HB = 88;
  localparam int VGA_BLK_VF = 1;
  localparam int VGA_BLK_VT = 4;
  localparam int VGA_BLK_VB = 23;

  localparam int H_TOTAL      = VGA_RES_H + VGA_BLK_HF + VGA_BLK_HT + VGA_BLK_HB;
  localparam int V_TOTAL      = VGA_RES_V + VGA_BLK_VF + VGA_BLK_VT + VGA_BLK_VB;
  localparam int H_SYNC_START = VGA_RES_H + VGA_BLK_HF;
  localparam int H_SYNC_END   = H_SYNC_START + VGA_BLK_HT;
  localparam int V_SYNC_START = VGA_RES_V + VGA_BLK_VF;
  localparam int V_SYNC_END   = V_SYNC_START + VGA_BLK_VT;

  // Modulo-total increment used for both the pixel and the line counter.
  function automatic coord_t coord_inc(input coord_t c, input coord_t total);
    return (c == total - coord_t'(1)) ? '0 : c + coord_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_sync_edge : two-stage sync sampler producing one-cycle rise/fall pulses
// Revision: 1.0
// ----------------------------------------------------------------------------
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sync_in;
      s2 <= s1;
    end
  end

  // Pulses are aligned with the first stage-1 sample at the new level.
  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

endmodule
`default_nettype wire

// File: rtl/vga_rx_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_rx_decoder : locks onto VGA sync timing and recovers a per-pixel stream
// Revision: 1.0
// ----------------------------------------------------------------------------
module vga_rx_decoder
  import vga_pkg::*;
#(
  parameter int RES_H  = VGA_RES_H,
  parameter int RES_V  = VGA_RES_V,
  parameter int BLK_HF = VGA_BLK_HF,
  parameter int BLK_HT = VGA_BLK_HT,
  parameter int BLK_HB = VGA_BLK_HB,
  parameter int BLK_VF = VGA_BLK_VF,
  parameter int BLK_VT = VGA_BLK_VT,
  parameter int BLK_VB = VGA_BLK_VB,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       RGB,
  input  logic             HSYNC,
  input  logic             VSYNC,
  input  logic [10:0]      probe_x,
  input  logic [10:0]      probe_y,
  output logic             pix_valid,
  output logic [10:0]      pix_x,
  output logic [10:0]      pix_y,
  output logic [2:0]       pix_rgb,
  output logic             frame_done,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             blank_violation,
  output logic [2:0]       probe_rgb,
  output logic             probe_valid
);

  localparam coord_t LINE_LEN  = coord_t'(RES_H + BLK_HF + BLK_HT + BLK_HB);
  localparam coord_t FRAME_LEN = coord_t'(RES_V + BLK_VF + BLK_VT + BLK_VB);
  localparam coord_t HS_RISE_H = coord_t'(RES_H + BLK_HF);
  localparam coord_t HS_FALL_H = coord_t'(RES_H + BLK_HF + BLK_HT);
  localparam coord_t VS_RISE_V = coord_t'(RES_V + BLK_VF);
  localparam coord_t VS_FALL_V = coord_t'(RES_V + BLK_VF + BLK_VT);
  localparam coord_t VIS_H     = coord_t'(RES_H);
  localparam coord_t VIS_V     = coord_t'(RES_V);
  localparam coord_t LAST_X    = coord_t'(RES_H - 1);
  localparam coord_t LAST_Y    = coord_t'(RES_V - 1);

  logic [2:0] rgb_s1;
  logic       hs_rise;
  logic       hs_fall;
  logic       vs_rise;
  logic       vs_fall;

  state_t state;
  state_t state_nxt;
  coord_t h;
  coord_t v;
  coord_t h_nxt;
  coord_t v_nxt;
  logic   wrapped;
  logic   wrapped_nxt;
  logic   line_end;
  logic   sync_err;

  logic visible;
  logic pix_ok;
  logic probe_hit;
  logic enter_hunt;

  vga_sync_edge u_hs_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_in (HSYNC),
    .rise    (hs_rise),
    .fall    (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_in (VSYNC),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1 <= 3'b000;
    end else begin
      rgb_s1 <= RGB;
    end
  end

  // h/v always name the sample currently held in stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      h       <= '0;
      v       <= '0;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      h       <= h_nxt;
      v       <= v_nxt;
      wrapped <= wrapped_nxt;
    end
  end

  always_comb begin
    sync_err    = 1'b0;
    state_nxt   = state;
    h_nxt       = h;
    v_nxt       = v;
    wrapped_nxt = wrapped;
    line_end    = (h == LINE_LEN - coord_t'(1));

    if (state != HUNT) begin
      if (hs_rise && (h != HS_RISE_H)) sync_err = 1'b1;
      if (hs_fall && (h != HS_FALL_H)) sync_err = 1'b1;
      if (vs_rise && ((h != '0) || (v != VS_RISE_V))) sync_err = 1'b1;
      if (vs_fall && ((h != '0) || (v != VS_FALL_V))) sync_err = 1'b1;
    end

    case (state)
      HUNT: begin
        // The rising sample is (0, VS_RISE_V); the next one is its successor.
        if (vs_rise) begin
          state_nxt   = TRACK;
          h_nxt       = coord_inc('0, LINE_LEN);
          v_nxt       = VS_RISE_V;
          wrapped_nxt = 1'b0;
        end
      end
      TRACK, LOCKED: begin
        if (sync_err) begin
          state_nxt   = HUNT;
          h_nxt       = '0;
          v_nxt       = '0;
          wrapped_nxt = 1'b0;
        end else begin
          h_nxt = coord_inc(h, LINE_LEN);
          if (line_end) begin
            v_nxt = coord_inc(v, FRAME_LEN);
            if (v == FRAME_LEN - coord_t'(1)) wrapped_nxt = 1'b1;
          end
          if ((state == TRACK) && vs_rise && wrapped) state_nxt = LOCKED;
        end
      end
      default: begin
        state_nxt   = HUNT;
        h_nxt       = '0;
        v_nxt       = '0;
        wrapped_nxt = 1'b0;
      end
    endcase
  end

  assign locked     = (state == LOCKED);
  assign visible    = (h < VIS_H) && (v < VIS_V);
  assign pix_ok     = locked && !sync_err && visible;
  assign probe_hit  = pix_ok && (h == probe_x) && (v == probe_y);
  assign enter_hunt = (state != HUNT) && (state_nxt == HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid       <= 1'b0;
      pix_x           <= '0;
      pix_y           <= '0;
      pix_rgb         <= 3'b000;
      frame_done      <= 1'b0;
      err_cnt         <= '0;
      blank_violation <= 1'b0;
      probe_rgb       <= 3'b000;
      probe_valid     <= 1'b0;
    end else begin
      pix_valid  <= pix_ok;
      pix_x      <= pix_ok ? h : '0;
      pix_y      <= pix_ok ? v : '0;
      pix_rgb    <= pix_ok ? rgb_s1 : 3'b000;
      frame_done <= pix_ok && (h == LAST_X) && (v == LAST_Y);

      if (sync_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);

      if (locked && !visible && (rgb_s1 != 3'b000)) blank_violation <= 1'b1;

      if (probe_hit) begin
        probe_rgb   <= rgb_s1;
        probe_valid <= 1'b1;
      end else if (enter_hunt) begin
        probe_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_rx_decoder : directed bench on a reduced 16x8 raster (25x13 total)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_vga_rx_decoder;

  localparam int RES_H  = 16;
  localparam int RES_V  = 8;
  localparam int BLK_HF = 2;
  localparam int BLK_HT = 4;
  localparam int BLK_HB = 3;
  localparam int BLK_VF = 1;
  localparam int BLK_VT = 2;
  localparam int BLK_VB = 2;
  localparam int ERR_W  = 8;

  localparam int LINE   = 25;  // 16+2+4+3
  localparam int FRAME  = 13;  // 8+1+2+2
  localparam int HS_ON  = 18;
  localparam int HS_OFF = 22;
  localparam int VS_ON  = 9;
  localparam int VS_OFF = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       RGB = 3'b000;
  logic             HSYNC = 1'b0;
  logic             VSYNC = 1'b0;
  logic [10:0]      probe_x = 11'd900;
  logic [10:0]      probe_y = 11'd10;
  logic             pix_valid;
  logic [10:0]      pix_x;
  logic [10:0]      pix_y;
  logic [2:0]       pix_rgb;
  logic             frame_done;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;
  logic             blank_violation;
  logic [2:0]       probe_rgb;
  logic             probe_valid;

  int n_cmp = 0;
  int n_err = 0;

  int gh = 0;
  int gv = 0;
  int hist_h = 0;
  int hist_v = 0;
  logic hs_late = 1'b0;
  int hs_late_v = 0;
  logic ovr_en = 1'b0;
  int ovr_h = 0;
  int ovr_v = 0;
  logic [2:0] ovr_rgb = 3'b000;
  int mon_pix = 0;
  int mon_fd = 0;

  vga_rx_decoder #(
    .RES_H  (RES_H),
    .RES_V  (RES_V),
    .BLK_HF (BLK_HF),
    .BLK_HT (BLK_HT),
    .BLK_HB (BLK_HB),
    .BLK_VF (BLK_VF),
    .BLK_VT (BLK_VT),
    .BLK_VB (BLK_VB),
    .ERR_W  (ERR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .RGB             (RGB),
    .HSYNC           (HSYNC),
    .VSYNC           (VSYNC),
    .probe_x         (probe_x),
    .probe_y         (probe_y),
    .pix_valid       (pix_valid),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_rgb         (pix_rgb),
    .frame_done      (frame_done),
    .locked          (locked),
    .err_cnt         (err_cnt),
    .blank_violation (blank_violation),
    .probe_rgb       (probe_rgb),
    .probe_valid     (probe_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Checkerboard in bit 2, position-coded low bits; black in blanking.
  function automatic logic [2:0] px_rgb(input int x, input int y);
    if (ovr_en && (x == ovr_h) && (y == ovr_v)) return ovr_rgb;
    if ((x < RES_H) && (y < RES_V)) return {x[0] ^ y[0], x[1], y[0]};
    return 3'b000;
  endfunction

  // Drive one golden pixel, then check the pixel driven one call earlier.
  task automatic gen_cycle();
    HSYNC = (gh >= HS_ON + ((hs_late && (gv == hs_late_v)) ? 1 : 0)) && (gh < HS_OFF);
    VSYNC = (gv >= VS_ON) && (gv < VS_OFF);
    RGB   = px_rgb(gh, gv);
    @(posedge clk);
    #1;
    if (pix_valid) begin
      mon_pix++;
      check("pix_xy", {pix_x, pix_y}, {11'(hist_h), 11'(hist_v)});
      check("pix_rgb", pix_rgb, px_rgb(hist_h, hist_v));
    end
    if (frame_done) begin
      mon_fd++;
      check("frame_done_pos", {pix_valid, pix_x, pix_y}, {1'b1, 11'(RES_H - 1), 11'(RES_V - 1)});
    end
    hist_h = gh;
    hist_v = gv;
    if (gh == LINE - 1) begin
      gh = 0;
      gv = (gv == FRAME - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
  endtask

  task automatic run_to(input int h, input int v);
    while (!((gh == h) && (gv == v))) gen_cycle();
  endtask

  task automatic pin_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pin_cycles(3);
    check("rst_pix", {pix_valid, pix_x, pix_y, pix_rgb, frame_done, locked}, 0);
    check("rst_status", {err_cnt, blank_violation, probe_rgb, probe_valid}, 0);
    rst_n = 1'b1;

    // First VSYNC rise only starts tracking; the second one locks.
    run_to(0, VS_ON);
    gen_cycle();
    gen_cycle();
    check("track_not_locked", locked, 0);
    run_to(0, 0);
    run_to(0, VS_ON);
    gen_cycle();
    check("lock_early", locked, 0);
    gen_cycle();
    check("lock_rise", locked, 1);

    mon_pix = 0;
    mon_fd  = 0;
    repeat (3 * LINE * FRAME) gen_cycle();
    check("pix_count", mon_pix, 3 * RES_H * RES_V);
    check("frame_done_count", mon_fd, 3);
    check("err_clean", err_cnt, 0);
    check("lock_hold", locked, 1);

    // HSYNC rise one clock late on the middle line.
    hs_late   = 1'b1;
    hs_late_v = RES_V / 2;
    run_to(HS_ON + 1, RES_V / 2);
    gen_cycle();
    check("lock_before_err", locked, 1);
    gen_cycle();
    check("lock_drop", locked, 0);
    check("err_one", err_cnt, 1);
    hs_late = 1'b0;
    mon_pix = 0;
    run_to(0, 0);
    check("valid_stop", mon_pix, 0);
    run_to(0, VS_ON);
    gen_cycle();
    check("relock_early", locked, 0);
    gen_cycle();
    check("relock", locked, 1);
    check("err_still_one", err_cnt, 1);

    // Probe on the last visible pixel, then move it out of range.
    check("probe_pre", probe_valid, 0);
    probe_x = 11'(RES_H - 1);
    probe_y = 11'(RES_V - 1);
    ovr_en  = 1'b1;
    ovr_h   = RES_H - 1;
    ovr_v   = RES_V - 1;
    ovr_rgb = 3'b101;
    run_to(0, RES_V);
    check("probe_rgb", probe_rgb, 3'b101);
    check("probe_valid", probe_valid, 1);
    probe_x = 11'd900;
    probe_y = 11'd10;
    ovr_rgb = 3'b010;
    run_to(0, 0);
    run_to(0, RES_V);
    check("probe_hold_rgb", probe_rgb, 3'b101);
    check("probe_hold_valid", probe_valid, 1);

    // Colour in the front porch while locked.
    check("blank_pre", blank_violation, 0);
    ovr_h   = RES_H + 1;
    ovr_v   = 3;
    ovr_rgb = 3'b001;
    run_to(0, 0);
    run_to(0, 4);
    check("blank_set", blank_violation, 1);
    check("blank_lock", locked, 1);
    ovr_en = 1'b0;
    run_to(0, 0);
    run_to(0, 4);
    check("blank_sticky", blank_violation, 1);
    check("blank_err", err_cnt, 1);

    // Reset mid-frame: outputs clear at once, relock on the second rise.
    run_to(RES_H / 2, RES_V / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_pix", {pix_valid, pix_x, pix_y, pix_rgb, frame_done, locked}, 0);
    check("midrst_status", {err_cnt, blank_violation, probe_rgb, probe_valid}, 0);
    gen_cycle();
    gen_cycle();
    rst_n = 1'b1;
    run_to(0, VS_ON);
    gen_cycle();
    gen_cycle();
    check("midrst_track", locked, 0);
    run_to(0, 0);
    run_to(0, VS_ON);
    gen_cycle();
    check("midrst_early", locked, 0);
    gen_cycle();
    check("midrst_relock", locked, 1);

    // Short corrupted VSYNC pulses: each misplaced fall costs one error.
    HSYNC = 1'b0;
    RGB   = 3'b000;
    for (int i = 0; i < 300; i++) begin
      VSYNC = 1'b0;
      pin_cycles(2);
      VSYNC = 1'b1;
      pin_cycles(2);
      if (i == 99) check("err_mid", err_cnt, 100);
    end
    check("err_sat", err_cnt, 255);
    check("sat_unlocked", locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
